// File: rtl/trace_dump_if.sv
// Bundle of start/status, trace RAM read port and UART TX handshake for trace_dump.
// The abort input exists only when DUMP_ABORT_EN is defined.
interface trace_dump_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] trace_end;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] tx_data;
  logic              trmt;
  logic              tx_done;
  logic              busy;
  logic              done;
`ifdef DUMP_ABORT_EN
  logic              abort;
`endif

  // Dump engine side
  modport master (
    input  start, trace_end, len, rdata, tx_done,
`ifdef DUMP_ABORT_EN
    input  abort,
`endif
    output raddr, ren, tx_data, trmt, busy, done
  );

  // Command processor / RAM / UART side
  modport slave (
    output start, trace_end, len, rdata, tx_done,
`ifdef DUMP_ABORT_EN
    output abort,
`endif
    input  raddr, ren, tx_data, trmt, busy, done
  );
endinterface

// File: rtl/trace_dump.sv
// Reads the circular trace RAM oldest-to-newest and sends each sample as one UART byte.
// Define DUMP_ABORT_EN to add the abort input (stop after the byte in flight).
module trace_dump #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  trace_dump_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] raddr_reg, raddr_next;
  logic [ADDR_W:0]   remaining_reg, remaining_next;
  logic [DATA_W-1:0] tx_data_reg, tx_data_next;
  logic              done_reg, done_next;
  logic              abort_pend_reg, abort_pend_next;
  logic [ADDR_W:0]   eff_len;
  logic              abort_in;

`ifdef DUMP_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  // A request longer than the RAM still sends each sample exactly once
  assign eff_len = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      raddr_reg      <= '0;
      remaining_reg  <= '0;
      tx_data_reg    <= '0;
      done_reg       <= 1'b0;
      abort_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      raddr_reg      <= raddr_next;
      remaining_reg  <= remaining_next;
      tx_data_reg    <= tx_data_next;
      done_reg       <= done_next;
      abort_pend_reg <= abort_pend_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    raddr_next      = raddr_reg;
    remaining_next  = remaining_reg;
    tx_data_next    = tx_data_reg;
    done_next       = 1'b0;
    abort_pend_next = abort_pend_reg;

    case (state_reg)
      IDLE: begin
        abort_pend_next = 1'b0;
        if (bus.start) begin
          if (eff_len != '0) begin
            raddr_next     = bus.trace_end + ADDR_W'(1);
            remaining_next = eff_len;
            state_next     = READ;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      READ: begin
        if (abort_in) begin
          remaining_next = '0;
          done_next      = 1'b1;
          state_next     = IDLE;
        end else begin
          state_next = LATCH;
        end
      end

      LATCH: begin
        if (abort_in) begin
          remaining_next = '0;
          done_next      = 1'b1;
          state_next     = IDLE;
        end else begin
          tx_data_next = bus.rdata;
          state_next   = SEND;
        end
      end

      SEND: begin
        if (abort_in) abort_pend_next = 1'b1;
        state_next = WAIT_TX;
      end

      WAIT_TX: begin
        if (abort_in) abort_pend_next = 1'b1;
        if (bus.tx_done) begin
          remaining_next = remaining_reg - ONE_L;
          // An abort seen while the byte was in flight ends the dump here
          if (remaining_reg == ONE_L || abort_pend_reg || abort_in) begin
            remaining_next = '0;
            done_next      = 1'b1;
            state_next     = IDLE;
          end else begin
            raddr_next = raddr_reg + ADDR_W'(1);
            state_next = READ;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.raddr   = raddr_reg;
  assign bus.ren     = (state_reg == READ);
  assign bus.tx_data = tx_data_reg;
  assign bus.trmt    = (state_reg == SEND);
  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = done_reg;

  a_ren_trmt_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.ren && bus.trmt));
  a_trmt_after_latch : assert property (@(posedge clk) disable iff (!rst_n)
    bus.trmt |-> $past(state_reg == LATCH));

endmodule

// File: doc/trace_dump.md
Name: trace_dump

Overview:
- Read-side counterpart of the capture controller. After a capture finishes, it reads the circular trace RAM from the oldest sample to the newest.
- Each sample goes out one byte at a time through the UART transmitter, using the trmt/tx_done handshake.
- Sits between the trace RAM read port and the UART TX, and is started by the command processor.

Parameters:
- ADDR_W, 9, trace RAM address width; depth = 2**ADDR_W (512).
- DATA_W, 8, sample width (one UART byte per sample).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE
- trace_end  input  ADDR_W  address of the last sample written by capture; sampled on start
- len  input  ADDR_W+1  number of samples to send; sampled on start
- raddr  output  ADDR_W  trace RAM read address (registered)
- ren  output  1  trace RAM read enable
- rdata  input  DATA_W  trace RAM read data, valid one clk after ren
- tx_data  output  DATA_W  byte to UART TX (registered)
- trmt  output  1  one-cycle pulse: UART starts sending tx_data
- tx_done  input  1  pulse from UART: byte fully sent
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the dump completes

Behaviour:
- One clock domain: clk, with asynchronous active-low reset rst_n.
- Reset values: all outputs 0, state IDLE, internal remaining count 0. Reset mid-dump aborts immediately with no further trmt.
- Counts:
  - Effective length = min(len, 2**ADDR_W).
  - Start address = trace_end+1 mod 2**ADDR_W, so the oldest sample goes first.
  - Address increments wrap from 2**ADDR_W-1 to 0.
  - remaining is ADDR_W+1 bits wide.
- IDLE:
  - start=1 and effective len>0: load raddr and remaining, busy<=1, go to READ.
  - start=1 and len=0: done pulses on the next cycle, busy stays 0, no ren and no trmt.
- READ: ren=1 for exactly one cycle; go to LATCH.
- LATCH: tx_data<=rdata; go to SEND.
- SEND: trmt=1 for exactly one cycle; go to WAIT_TX.
- WAIT_TX: wait for tx_done.
  - On tx_done: remaining<=remaining-1.
  - If remaining was 1: done=1 and busy=0 on the next cycle, go to IDLE.
  - Otherwise: raddr<=raddr+1 with wrap, go to READ.
- Latency: start sampled at edge k gives ren high in cycle k+1 and trmt high in cycle k+3. Each subsequent byte has trmt 3 cycles after the previous tx_done edge.
- Edge cases:
  - start while busy is ignored; trace_end and len changes during a dump are ignored.
  - tx_done outside WAIT_TX is ignored.
  - tx_done in the same cycle as trmt does not count (that cycle is SEND, not WAIT_TX).
- ren and trmt are never high in the same cycle. tx_data is stable from the cycle trmt is high until the next LATCH.

Optional Feature:
- Macro: DUMP_ABORT_EN.
- With it defined:
  - Adds input abort (1 bit).
  - abort in READ or LATCH: go to IDLE next cycle, no trmt, done pulses.
  - abort in SEND or WAIT_TX: the current byte completes (wait for tx_done), then IDLE with a done pulse and no further reads.
  - abort in IDLE is ignored.
- Without it: no abort port; a dump runs only to completion or reset.

Test Plan:
- trace_end=10, len=4, tx_done returned 5 cycles after each trmt -> raddr sequence 11,12,13,14; tx_data equals the RAM contents at those addresses; 4 trmt pulses; one done pulse; busy low afterwards.
- trace_end=510, len=4 -> raddr 511,0,1,2 (wrap verified).
- len=0 -> done pulses 1 cycle after start; ren, trmt and busy stay 0.
- len=600 (>512) with trace_end=0 -> exactly 512 trmt pulses, starting at address 1 and ending at address 0.
- Second start and a stray tx_done pulse in READ, during a len=3 dump -> still exactly 3 bytes; the stray pulse does not advance the count.
- Reset asserted during WAIT_TX of byte 2 -> all outputs 0 immediately. With DUMP_ABORT_EN: abort in WAIT_TX of byte 2 of len=5 -> byte 2 finishes, no byte 3, done pulses after tx_done.
